// File: rtl/uart_number_parser_pkg.sv
// Shared constants for the UART decimal number parser: ASCII codes,
// error codes and parser state encodings.
package uart_number_parser_pkg;

  // ASCII characters recognised by the parser
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;

  // Error codes reported on error_code
  localparam logic [3:0] ERR_NONE     = 4'd0;
  localparam logic [3:0] ERR_BAD_CHAR = 4'd1;
  localparam logic [3:0] ERR_OVERFLOW = 4'd2;

  // Parser state encodings
  localparam logic [1:0] PS_IDLE   = 2'd0;
  localparam logic [1:0] PS_SIGN   = 2'd1;
  localparam logic [1:0] PS_DIGITS = 2'd2;
  localparam logic [1:0] PS_FLUSH  = 2'd3;

endpackage

// File: rtl/uart_number_parser_classify.sv
// ascii_classify: combinational byte classifier for the number parser.
// Bytes with bit7 set match no class and are therefore illegal characters.
module ascii_classify
  import uart_number_parser_pkg::*;
(
  input  logic [7:0] byte_in,
  output logic       is_digit,
  output logic [3:0] digit,
  output logic       is_sep,
  output logic       is_eol,
  output logic       is_minus
);

  // Decode the byte into its character classes
  always_comb begin
    is_digit = (byte_in >= CH_0) && (byte_in <= CH_9);
    digit    = is_digit ? byte_in[3:0] : '0;
    is_eol   = (byte_in == CH_CR) || (byte_in == CH_LF);
    is_sep   = is_eol || (byte_in == CH_SPACE) || (byte_in == CH_COMMA);
    is_minus = (byte_in == CH_MINUS);
  end

endmodule

// File: rtl/uart_number_parser.sv
// uart_number_parser: turns a UART byte stream into signed-magnitude
// decimal tokens. One byte per cycle, no backpressure. Completed tokens
// and errors are reported as registered one-cycle pulses.
module uart_number_parser
  import uart_number_parser_pkg::*;
#(
  parameter int VALUE_WIDTH = 8,
  parameter int MAX_DIGITS  = 3,
  parameter int ALLOW_NEG   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   flush,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic [VALUE_WIDTH-1:0] num_value,
  output logic                   num_neg,
  output logic                   num_valid,
  output logic                   num_eol,
  output logic                   parse_error,
  output logic [3:0]             error_code,
  output logic                   busy
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam int EXT_W = VALUE_WIDTH + 4;

  logic [1:0]             state_q, state_d;
  logic [VALUE_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]       digit_cnt_q, digit_cnt_d;
  logic                   neg_q, neg_d;
  logic [VALUE_WIDTH-1:0] num_value_q, num_value_d;
  logic                   num_neg_q, num_neg_d;
  logic                   num_valid_q, num_valid_d;
  logic                   num_eol_q, num_eol_d;
  logic                   parse_error_q, parse_error_d;
  logic [3:0]             error_code_q, error_code_d;

  logic                   cls_is_digit;
  logic [3:0]             cls_digit;
  logic                   cls_is_sep;
  logic                   cls_is_eol;
  logic                   cls_is_minus;

  logic [EXT_W-1:0]       acc_next_ext;
  logic                   acc_overflow;

  ascii_classify u_classify (
    .byte_in  (rx_data),
    .is_digit (cls_is_digit),
    .digit    (cls_digit),
    .is_sep   (cls_is_sep),
    .is_eol   (cls_is_eol),
    .is_minus (cls_is_minus)
  );

  // Widened acc*10+d so an over-range value is detected instead of wrapping
  always_comb begin
    acc_next_ext = ({4'b0000, acc_q} * EXT_W'(10)) + EXT_W'(cls_digit);
    acc_overflow = (digit_cnt_q == CNT_W'(MAX_DIGITS)) ||
                   (acc_next_ext > {4'b0000, {VALUE_WIDTH{1'b1}}});
  end

  // Next-state logic: FSM, accumulator and output registers
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    digit_cnt_d   = digit_cnt_q;
    neg_d         = neg_q;
    num_value_d   = num_value_q;
    num_neg_d     = num_neg_q;
    num_valid_d   = 1'b0;
    num_eol_d     = num_eol_q;
    parse_error_d = 1'b0;
    error_code_d  = error_code_q;

    if (!enable || flush) begin
      state_d     = PS_IDLE;
      acc_d       = '0;
      digit_cnt_d = '0;
      neg_d       = 1'b0;
    end else if (rx_valid) begin
      case (state_q)
        PS_IDLE: begin
          if (cls_is_sep) begin
            state_d = PS_IDLE;
          end else if (cls_is_digit) begin
            acc_d       = VALUE_WIDTH'(cls_digit);
            digit_cnt_d = CNT_W'(1);
            state_d     = PS_DIGITS;
          end else if (cls_is_minus && (ALLOW_NEG != 0)) begin
            neg_d   = 1'b1;
            state_d = PS_SIGN;
          end else begin
            parse_error_d = 1'b1;
            error_code_d  = ERR_BAD_CHAR;
            state_d       = PS_FLUSH;
          end
        end
        PS_SIGN: begin
          if (cls_is_digit) begin
            acc_d       = VALUE_WIDTH'(cls_digit);
            digit_cnt_d = CNT_W'(1);
            state_d     = PS_DIGITS;
          end else begin
            parse_error_d = 1'b1;
            error_code_d  = ERR_BAD_CHAR;
            neg_d         = 1'b0;
            state_d       = cls_is_sep ? PS_IDLE : PS_FLUSH;
          end
        end
        PS_DIGITS: begin
          if (cls_is_digit) begin
            if (acc_overflow) begin
              parse_error_d = 1'b1;
              error_code_d  = ERR_OVERFLOW;
              state_d       = PS_FLUSH;
            end else begin
              acc_d       = acc_next_ext[VALUE_WIDTH-1:0];
              digit_cnt_d = digit_cnt_q + CNT_W'(1);
            end
          end else if (cls_is_sep) begin
            num_valid_d  = 1'b1;
            num_value_d  = acc_q;
            num_neg_d    = neg_q;
            num_eol_d    = cls_is_eol;
            error_code_d = ERR_NONE;
            acc_d        = '0;
            digit_cnt_d  = '0;
            neg_d        = 1'b0;
            state_d      = PS_IDLE;
          end else begin
            parse_error_d = 1'b1;
            error_code_d  = ERR_BAD_CHAR;
            state_d       = PS_FLUSH;
          end
        end
        default: begin
          // PS_FLUSH: swallow the rest of the bad token silently
          if (cls_is_sep) begin
            acc_d       = '0;
            digit_cnt_d = '0;
            neg_d       = 1'b0;
            state_d     = PS_IDLE;
          end
        end
      endcase
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= PS_IDLE;
      acc_q         <= '0;
      digit_cnt_q   <= '0;
      neg_q         <= 1'b0;
      num_value_q   <= '0;
      num_neg_q     <= 1'b0;
      num_valid_q   <= 1'b0;
      num_eol_q     <= 1'b0;
      parse_error_q <= 1'b0;
      error_code_q  <= ERR_NONE;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      digit_cnt_q   <= digit_cnt_d;
      neg_q         <= neg_d;
      num_value_q   <= num_value_d;
      num_neg_q     <= num_neg_d;
      num_valid_q   <= num_valid_d;
      num_eol_q     <= num_eol_d;
      parse_error_q <= parse_error_d;
      error_code_q  <= error_code_d;
    end
  end

  assign num_value   = num_value_q;
  assign num_neg     = num_neg_q;
  assign num_valid   = num_valid_q;
  assign num_eol     = num_eol_q;
  assign parse_error = parse_error_q;
  assign error_code  = error_code_q;
  assign busy        = (state_q != PS_IDLE);

endmodule

// File: tb/tb_uart_number_parser.sv
// Directed bench for uart_number_parser: a default instance plus an
// ALLOW_NEG=0 instance sharing the same byte stream.
module tb_uart_number_parser;

  logic       clk = 1'b0;
  logic       rst, enable, flush, rx_valid;
  logic [7:0] rx_data;

  logic [7:0] num_value, num_value_b;
  logic       num_neg, num_valid, num_eol, parse_error, busy;
  logic       num_neg_b, num_valid_b, num_eol_b, parse_error_b, busy_b;
  logic [3:0] error_code, error_code_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_number_parser #(.VALUE_WIDTH(8), .MAX_DIGITS(3), .ALLOW_NEG(1)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .num_value(num_value), .num_neg(num_neg), .num_valid(num_valid),
    .num_eol(num_eol), .parse_error(parse_error), .error_code(error_code),
    .busy(busy)
  );

  uart_number_parser #(.VALUE_WIDTH(8), .MAX_DIGITS(3), .ALLOW_NEG(0)) u_noneg (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .num_value(num_value_b), .num_neg(num_neg_b), .num_valid(num_valid_b),
    .num_eol(num_eol_b), .parse_error(parse_error_b), .error_code(error_code_b),
    .busy(busy_b)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one byte for one clock; outputs are sampled 1 time unit after the edge
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Completed-token check on the default instance
  task automatic chk_num(input string tag, input int v, input int n, input int e);
    chk({tag, ".valid"}, int'(num_valid), 1);
    chk({tag, ".value"}, int'(num_value), v);
    chk({tag, ".neg"},   int'(num_neg), n);
    chk({tag, ".eol"},   int'(num_eol), e);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; flush = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    @(posedge clk); @(posedge clk); #1;
    chk("rst.value", int'(num_value), 0);
    chk("rst.valid", int'(num_valid), 0);
    chk("rst.err",   int'(parse_error), 0);
    chk("rst.code",  int'(error_code), 0);
    chk("rst.busy",  int'(busy), 0);
    rst = 1'b0;
    idle();

    // "12 7\r"
    send("1"); chk("t1.busy1", int'(busy), 1); chk("t1.nv1", int'(num_valid), 0);
    send("2"); chk("t1.nv2", int'(num_valid), 0);
    send(" "); chk_num("t1.tok12", 12, 0, 0); chk("t1.busy_sp", int'(busy), 0);
    send("7"); chk("t1.nv7", int'(num_valid), 0);
    send(8'h0D); chk_num("t1.tok7", 7, 0, 1);
    idle(); chk("t1.pulse", int'(num_valid), 0);

    // "255 256 "
    send("2"); send("5"); send("5");
    send(" "); chk_num("t2.tok255", 255, 0, 0);
    send("2"); send("5");
    send("6"); chk("t2.err", int'(parse_error), 1); chk("t2.code", int'(error_code), 2);
    chk("t2.nv6", int'(num_valid), 0);
    send(" "); chk("t2.nv_sp", int'(num_valid), 0); chk("t2.busy", int'(busy), 0);
    chk("t2.err_sp", int'(parse_error), 0); chk("t2.hold", int'(num_value), 255);
    chk("t2.code_hold", int'(error_code), 2);

    // Digit-count overflow with a small value: "0012 "
    send("0"); send("0"); send("1");
    send("2"); chk("t3.cnt_err", int'(parse_error), 1); chk("t3.cnt_code", int'(error_code), 2);
    send(" ");

    // "1234 " then "-5\n"
    send("1"); send("2"); send("3");
    send("4"); chk("t3.err4", int'(parse_error), 1); chk("t3.code4", int'(error_code), 2);
    send(" ");
    send("-"); chk("t3.busy_sign", int'(busy), 1); chk("t3.nerr", int'(parse_error), 0);
    chk("t3b.err", int'(parse_error_b), 1); chk("t3b.code", int'(error_code_b), 1);
    send("5"); chk("t3b.noerr5", int'(parse_error_b), 0);
    send(8'h0A); chk_num("t3.neg5", 5, 1, 1); chk("t3.code_clr", int'(error_code), 0);
    chk("t3b.nv", int'(num_valid_b), 0); chk("t3b.busy", int'(busy_b), 0);

    // "-0 " is legal
    send("-"); send("0");
    send(" "); chk_num("t3.neg0", 0, 1, 0);

    // "- " : sign followed by separator
    send("-");
    send(" "); chk("t3.sign_sep_err", int'(parse_error), 1);
    chk("t3.sign_sep_code", int'(error_code), 1); chk("t3.sign_sep_busy", int'(busy), 0);

    // "3a9 8 "
    send("3");
    send("a"); chk("t4.err_a", int'(parse_error), 1); chk("t4.code_a", int'(error_code), 1);
    send("9"); chk("t4.err9", int'(parse_error), 0);
    send(" "); chk("t4.nv_sp", int'(num_valid), 0); chk("t4.err_sp", int'(parse_error), 0);
    send("8");
    send(" "); chk_num("t4.tok8", 8, 0, 0); chk("t4.code_clr", int'(error_code), 0);

    // Byte with bit7 set
    send(8'hB1); chk("t4.hi_err", int'(parse_error), 1); chk("t4.hi_code", int'(error_code), 1);
    send(" "); chk("t4.hi_busy", int'(busy), 0);

    // flush coincident with the separator
    send("4");
    flush = 1'b1;
    send(" "); chk("t5.flush_nv", int'(num_valid), 0); chk("t5.flush_busy", int'(busy), 0);
    chk("t5.flush_hold", int'(num_value), 8);
    flush = 1'b0;

    // enable low coincident with the separator
    send("6");
    enable = 1'b0;
    send(" "); chk("t5.en_nv", int'(num_valid), 0); chk("t5.en_busy", int'(busy), 0);
    chk("t5.en_hold", int'(num_value), 8);
    enable = 1'b1;

    // Error code holds through a disable
    send("x"); chk("t5.x_code", int'(error_code), 1);
    enable = 1'b0;
    send(" "); chk("t5.en_code_hold", int'(error_code), 1); chk("t5.en_err", int'(parse_error), 0);
    enable = 1'b1;

    // rst mid-token
    send("9");
    rst = 1'b1;
    send(" "); chk("t5.rst_nv", int'(num_valid), 0); chk("t5.rst_value", int'(num_value), 0);
    chk("t5.rst_code", int'(error_code), 0); chk("t5.rst_busy", int'(busy), 0);
    rst = 1'b0;

    // "\r\n\r\n7," back to back
    send(8'h0D); chk("t6.nv_cr1", int'(num_valid), 0);
    send(8'h0A); chk("t6.nv_lf1", int'(num_valid), 0);
    send(8'h0D); chk("t6.nv_cr2", int'(num_valid), 0);
    send(8'h0A); chk("t6.nv_lf2", int'(num_valid), 0);
    send("7");   chk("t6.nv7", int'(num_valid), 0);
    send(",");   chk_num("t6.tok7", 7, 0, 0);
    idle(); chk("t6.single", int'(num_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_number_parser.md
Name: uart_number_parser

Overview:
- Upstream stage of the settings and matrix-entry modes. Converts the UART receive byte stream (rx_data/rx_valid) into decimal integers.
- Separators are space, CR, LF and ','. An optional leading '-' is accepted.
- Each completed number is delivered as a one-cycle num_valid pulse with value, sign and end-of-line flag; the consuming mode FSM latches it.
- Malformed tokens produce an error pulse; the parser then resynchronises on the next separator.

Parameters:
- VALUE_WIDTH, 8: magnitude width of num_value (unsigned).
- MAX_DIGITS, 3: maximum digits per token; more digits is an overflow error.
- ALLOW_NEG, 1: 1 accepts a leading '-'; 0 treats '-' as an illegal character.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- enable  in  1  parser active; driven by the owning mode's mode_active
- flush  in  1  discard any partial token and return to IDLE
- rx_data  in  8  received ASCII byte
- rx_valid  in  1  one-cycle strobe: rx_data is valid
- num_value  out  VALUE_WIDTH  magnitude of the last completed number
- num_neg  out  1  last completed number carried a '-'
- num_valid  out  1  one-cycle pulse: num_value/num_neg/num_eol valid
- num_eol  out  1  token was terminated by CR or LF
- parse_error  out  1  one-cycle pulse: token rejected
- error_code  out  4  code of the last error, held until the next token completes
- busy  out  1  a token is partially received (state != IDLE)

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, acc=0, digit_cnt=0, neg=0. All outputs are 0; error_code=ERR_NONE.
- Priority order per cycle: rst > !enable > flush > rx_valid.
  - enable=0 or flush=1: state←IDLE, acc/digit_cnt/neg cleared. That cycle's byte is ignored. num_value, num_neg and error_code hold; pulses are 0.
- Bytes are consumed only when rx_valid=1; there is no backpressure.
- States:
  - IDLE:
    - separator: stay.
    - digit: acc←d, digit_cnt←1, go to DIGITS.
    - '-' with ALLOW_NEG: neg←1, go to SIGN.
    - any other byte: error ERR_BAD_CHAR, go to FLUSH.
  - SIGN:
    - digit: as from IDLE, keeping neg.
    - separator or other byte: error ERR_BAD_CHAR. A separator returns to IDLE; any other byte goes to FLUSH.
  - DIGITS:
    - digit: if digit_cnt==MAX_DIGITS, or acc*10+d > 2^VALUE_WIDTH-1, raise ERR_OVERFLOW and go to FLUSH. Otherwise acc←acc*10+d, digit_cnt++.
    - separator: complete the token (next bullet), return to IDLE.
    - other byte: error ERR_BAD_CHAR, go to FLUSH.
  - FLUSH: discard bytes until a separator, then go to IDLE. No further error pulses inside one bad token.
- Completion timing: num_valid is registered and asserts the cycle after the separator's rx_valid (latency 1).
  - Same edge: num_value←acc, num_neg←neg, num_eol←(CR|LF), error_code←ERR_NONE.
- Error timing: parse_error asserts the cycle after the offending byte's rx_valid; error_code is updated on the same edge.
- Width rules: compute acc*10+d in VALUE_WIDTH+4 bits and compare against the all-ones VALUE_WIDTH bound. Never wrap.
- "-0" is legal: num_value=0, num_neg=1. The consumer decides its meaning.
- Back-to-back rx_valid on consecutive cycles must be handled; each byte costs one cycle.
- CR immediately followed by LF: the second separator is ignored in IDLE, so no empty token is produced.
- Bytes with bit7 set are treated as ERR_BAD_CHAR.

Decomposition:
- matrix_pkg.vh gains:
  - ASCII constants: CH_SPACE, CH_CR, CH_LF, CH_COMMA, CH_MINUS, CH_0, CH_9.
  - Error code ERR_BAD_CHAR (ERR_NONE already exists).
  - Error code ERR_OVERFLOW.
  - Parser state encodings PS_IDLE, PS_SIGN, PS_DIGITS, PS_FLUSH.
- One natural sub-module, ascii_classify (combinational): byte → is_digit, digit[3:0], is_sep, is_eol, is_minus.
- Keep the FSM and accumulator in the parent.

Test Plan:
- "12 7\r" with defaults → num_valid ×2: (12, neg=0, eol=0), then (7, neg=0, eol=1). Each pulse occurs 1 cycle after its separator.
- "255 256 " → 255 accepted. On '6': parse_error with ERR_OVERFLOW; no num_valid for 256; busy=0 after the trailing space.
- "1234 " (MAX_DIGITS=3) → ERR_OVERFLOW on '4'. Then "-5\n" → (5, neg=1, eol=1). Repeat with ALLOW_NEG=0 → ERR_BAD_CHAR on '-'.
- "3a9 8 " → ERR_BAD_CHAR on 'a', a single error pulse. "9" is discarded; next output is (8, eol=0).
- Send "4" then flush=1 coincident with rx_valid of " " → no num_valid, state IDLE. Repeat with enable=0 and rst=1 mid-token: outputs reset/hold per the priority rules.
- "\r\n\r\n7," with rx_valid every cycle → exactly one num_valid (7, eol=0); no empty tokens.
